// File: rtl/ind_pkg.sv
// Shared constants for the calculator display driver.
// Format codes, segment glyphs, FSM states and BCD helpers.
package ind_pkg;

  localparam logic [2:0] CODE_P  = 3'd0;
  localparam logic [2:0] CODE_M  = 3'd1;
  localparam logic [2:0] CODE_D0 = 3'd2;
  localparam logic [2:0] CODE_D  = 3'd4;

  localparam int NIB = 4;

  localparam logic [6:0] GL_0     = 7'b1000000;
  localparam logic [6:0] GL_1     = 7'b1111001;
  localparam logic [6:0] GL_2     = 7'b0100100;
  localparam logic [6:0] GL_3     = 7'b0110000;
  localparam logic [6:0] GL_4     = 7'b0011001;
  localparam logic [6:0] GL_5     = 7'b0010010;
  localparam logic [6:0] GL_6     = 7'b0000010;
  localparam logic [6:0] GL_7     = 7'b1111000;
  localparam logic [6:0] GL_8     = 7'b0000000;
  localparam logic [6:0] GL_9     = 7'b0010000;
  localparam logic [6:0] GL_MINUS = 7'b0111111;
  localparam logic [6:0] GL_E     = 7'b0000110;
  localparam logic [6:0] GL_R     = 7'b0101111;
  localparam logic [6:0] GL_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FMT
  } state_t;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0:    g = GL_0;
      4'd1:    g = GL_1;
      4'd2:    g = GL_2;
      4'd3:    g = GL_3;
      4'd4:    g = GL_4;
      4'd5:    g = GL_5;
      4'd6:    g = GL_6;
      4'd7:    g = GL_7;
      4'd8:    g = GL_8;
      4'd9:    g = GL_9;
      default: g = GL_BLANK;
    endcase
    return g;
  endfunction

  // Double-dabble adjust: +3 on every nibble >= 5 before the shift.
  function automatic logic [4*NIB-1:0] dabble(
    input logic [4*NIB-1:0] b
  );
    logic [4*NIB-1:0] r;
    r = b;
    for (int i = 0; i < NIB; i++) begin
      if (r[4*i+:4] >= 4'd5) r[4*i+:4] = r[4*i+:4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/ind_display_drv_bin2bcd.sv
// Sequential double-dabble binary to BCD converter.
// One shift per cycle, W cycles per conversion.
module bin2bcd_seq
  import ind_pkg::*;
#(
  parameter int W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     bin,
  output logic             done,
  output logic [4*NIB-1:0] bcd
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          busy;

  assign done = busy && (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      bcd  <= '0;
    end else if (start) begin
      sr   <= bin;
      cnt  <= '0;
      busy <= 1'b1;
      bcd  <= '0;
    end else if (busy) begin
      bcd <= {dabble(bcd)[4*NIB-2:0], sr[W-1]};
      sr  <= sr << 1;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ind_display_drv.sv
// Calculator result display: BCD convert, format, latch, scan.
// Drives a multiplexed active-low common-anode 7-segment display.
module ind_display_drv
  import ind_pkg::*;
#(
  parameter int IND_1    = 11,
  parameter int CONTROL  = 3,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk_IND,
  input  logic               rst_n_IND,
  input  logic [IND_1-1:0]   ind_1,
  input  logic [CONTROL-1:0] control,
  output logic [DIGITS-1:0]  an,
  output logic [6:0]         seg,
  output logic               dp,
  output logic               upd
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  state_t             st;
  logic [CONTROL-1:0] ctl_q;
  logic               start;
  logic               done;
  logic [4*NIB-1:0]   bcd;

  logic [6:0] lat  [DIGITS];
  logic       ldp  [DIGITS];
  logic [6:0] fseg [DIGITS];
  logic       fdp  [DIGITS];
  logic [3:0] nib  [DIGITS];
  int         ms;

  logic [PW-1:0] psc;
  logic [IW-1:0] idx;

  assign start = (st == S_IDLE);

  bin2bcd_seq #(
    .W(IND_1)
  ) u_b2b (
    .clk  (clk_IND),
    .rst_n(rst_n_IND),
    .start(start),
    .bin  (ind_1),
    .done (done),
    .bcd  (bcd)
  );

  // ms is the leftmost digit shown; blanking never goes below it.
  always_comb begin
    ms = 0;
    for (int i = 0; i < DIGITS; i++) begin
      nib[i]  = '0;
      fseg[i] = GL_BLANK;
      fdp[i]  = 1'b1;
    end
    for (int i = 0; i < NIB; i++) begin
      nib[i] = bcd[4*i+:4];
      if (nib[i] != 4'd0) ms = i;
    end
    if (ctl_q == CODE_D && ms < 2) ms = 2;
    if (ctl_q == CODE_D0) begin
      fseg[2] = GL_E;
      fseg[1] = GL_R;
      fseg[0] = GL_R;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i <= ms) fseg[i] = glyph(nib[i]);
        else if (ctl_q == CODE_M && i == ms + 1)
          fseg[i] = GL_MINUS;
      end
      if (ctl_q == CODE_D) fdp[2] = 1'b0;
    end
  end

  always_ff @(posedge clk_IND or negedge rst_n_IND) begin
    if (!rst_n_IND) begin
      st    <= S_IDLE;
      ctl_q <= '0;
      upd   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        lat[i] <= GL_BLANK;
        ldp[i] <= 1'b1;
      end
    end else begin
      upd <= 1'b0;
      unique case (st)
        S_IDLE: begin
          ctl_q <= control;
          st    <= S_CONV;
        end
        S_CONV: if (done) st <= S_FMT;
        S_FMT: begin
          for (int i = 0; i < DIGITS; i++) begin
            lat[i] <= fseg[i];
            ldp[i] <= fdp[i];
          end
          upd <= 1'b1;
          st  <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_IND or negedge rst_n_IND) begin
    if (!rst_n_IND) begin
      psc <= '0;
      idx <= '0;
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      if (psc == PW'(SCAN_DIV - 1)) begin
        psc <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        psc <= psc + 1'b1;
      end
      an  <= ~(DIGITS'(1) << idx);
      seg <= lat[idx];
      dp  <= ldp[idx];
    end
  end

endmodule

// File: tb/tb_ind_display_drv.sv
// Directed vector bench for ind_display_drv.
// Table of format cases plus hand-written timing sequences.
module tb_ind_display_drv;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] GM = 7'b0111111;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GR = 7'b0101111;
  localparam logic [6:0] GB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ind_1 = '0;
  logic [2:0]  control = '0;
  logic [4:0]  an, an4;
  logic [6:0]  seg, seg4;
  logic        dp, dp4, upd, upd4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ind_display_drv #(
    .IND_1(11), .CONTROL(3), .DIGITS(5), .SCAN_DIV(2)
  ) dut (
    .clk_IND(clk), .rst_n_IND(rst_n), .ind_1(ind_1),
    .control(control), .an(an), .seg(seg), .dp(dp), .upd(upd)
  );

  ind_display_drv #(
    .IND_1(11), .CONTROL(3), .DIGITS(5), .SCAN_DIV(4)
  ) dut4 (
    .clk_IND(clk), .rst_n_IND(rst_n), .ind_1(ind_1),
    .control(control), .an(an4), .seg(seg4), .dp(dp4), .upd(upd4)
  );

  typedef struct packed {
    logic [2:0]  ctl;
    logic [10:0] val;
    logic [34:0] segs;
    logic [4:0]  dps;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_upd(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!upd && n < 40);
    nvec++;
    if (!upd) begin
      nerr++;
      $display("FAIL %s: got no upd want upd within 40", nm);
    end
  endtask

  task automatic scan(output logic [34:0] s, output logic [4:0] d);
    int hot;
    s = 'x;
    d = 'x;
    repeat (11) begin
      @(posedge clk); #1;
      hot = -1;
      for (int i = 0; i < 5; i++)
        if (an == ~(5'b1 << i)) hot = i;
      chk("an_onehot", an, (hot >= 0) ? an : 64'hFFFF);
      if (hot >= 0) begin
        s[7*hot+:7] = seg;
        d[hot] = dp;
      end
    end
  endtask

  task automatic cmp_disp(input string nm, input logic [34:0] es,
                          input logic [4:0] ed);
    logic [34:0] s;
    logic [4:0]  d;
    scan(s, d);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_seg%0d", nm, i), s[7*i+:7], es[7*i+:7]);
      chk($sformatf("%s_dp%0d", nm, i), d[i], ed[i]);
    end
  endtask

  initial begin
    int first, second;
    logic [4:0] prev;
    int run;
    bit started;

    tbl[0] = '{3'd0, 11'd1234, {GB, G1, G2, G3, G4}, 5'b11111};
    tbl[1] = '{3'd1, 11'd7,    {GB, GB, GB, GM, G7}, 5'b11111};
    tbl[2] = '{3'd4, 11'd5,    {GB, GB, G0, G0, G5}, 5'b11011};
    tbl[3] = '{3'd4, 11'd1234, {GB, G1, G2, G3, G4}, 5'b11011};
    tbl[4] = '{3'd2, 11'd999,  {GB, GB, GE, GR, GR}, 5'b11111};
    tbl[5] = '{3'd0, 11'd2047, {GB, G2, G0, G4, G7}, 5'b11111};
    tbl[6] = '{3'd0, 11'd0,    {GB, GB, GB, GB, G0}, 5'b11111};
    tbl[7] = '{3'd1, 11'd2047, {GM, G2, G0, G4, G7}, 5'b11111};
    tbl[8] = '{3'd7, 11'd50,   {GB, GB, GB, G5, G0}, 5'b11111};
    tbl[9] = '{3'd1, 11'd0,    {GB, GB, GB, GM, G0}, 5'b11111};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 5'h1F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_upd", upd, 1'b0);

    ind_1 = 11'd1234;
    control = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    second = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (upd && first == 0) first = c;
      else if (upd && second == 0) second = c;
    end
    chk("first_upd_cycle", first, 13);
    chk("second_upd_cycle", second, 26);

    started = 1'b0;
    prev = an4;
    run = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (an4 != prev) begin
        if (started) begin
          chk("scan4_len", run, 4);
          chk("scan4_order", an4, {prev[3:0], prev[4]});
        end
        started = 1'b1;
        run = 1;
        prev = an4;
      end else begin
        run++;
      end
    end

    for (int v = 0; v < 10; v++) begin
      wait_upd("tbl_sync");
      ind_1 = tbl[v].val;
      control = tbl[v].ctl;
      wait_upd("tbl_upd");
      cmp_disp($sformatf("vec%0d", v), tbl[v].segs, tbl[v].dps);
    end

    wait_upd("mid_sync");
    ind_1 = 11'd2047;
    control = 3'd0;
    repeat (4) @(posedge clk);
    #1;
    ind_1 = 11'd0;
    wait_upd("mid_upd1");
    cmp_disp("mid_old", {GB, G2, G0, G4, G7}, 5'b11111);
    wait_upd("mid_upd2");
    cmp_disp("mid_new", {GB, GB, GB, GB, G0}, 5'b11111);

    ind_1 = 11'd1234;
    wait_upd("rst_sync");
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", an, 5'h1F);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dp", dp, 1'b1);
    chk("arst_upd", upd, 1'b0);
    chk("arst_an4", an4, 5'h1F);
    @(negedge clk);
    rst_n = 1'b1;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (upd && first == 0) first = c;
    end
    chk("rerelease_upd_cycle", first, 13);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
